// File: rtl/bready_mux_2_1_pkg.sv
// Shared interconnect definitions for the B-channel ready mux.
// Holds the port-select encoding used by the write-response path.
package bready_mux_2_1_pkg;

  typedef enum logic {
    SEL_S00 = 1'b0,
    SEL_S01 = 1'b1
  } sel_e;

endpackage

// File: rtl/bready_hs_counter.sv
// Saturating handshake counter with enable.
// Holds at all-ones instead of wrapping.
module bready_hs_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic sat;

  assign sat = &count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bready_mux_2_1.sv
// Two-input BREADY mux with a per-port handshake monitor.
// Ready path is purely combinational; only the monitor is clocked.
module bready_mux_2_1
  import bready_mux_2_1_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             Selected_Slave,
  input  logic             S00_AXI_bready,
  input  logic             S01_AXI_bready,
  input  logic             Sele_S_AXI_bvalid,
  output logic             Sele_S_AXI_bready,
  output logic [CNT_W-1:0] S00_bhs_count,
  output logic [CNT_W-1:0] S01_bhs_count,
  output logic             sel_changed
);

  logic is_s01;
  logic hs;
  logic en_s00;
  logic en_s01;
  logic sel_q;

  assign is_s01 = (Selected_Slave == SEL_S01);

  assign Sele_S_AXI_bready = is_s01 ? S01_AXI_bready
                                    : S00_AXI_bready;

  // Credit goes to whichever port is selected at the sampling edge.
  assign hs     = Sele_S_AXI_bvalid & Sele_S_AXI_bready;
  assign en_s00 = hs & ~is_s01;
  assign en_s01 = hs & is_s01;

  bready_hs_counter #(
    .CNT_W(CNT_W)
  ) u_cnt_s00 (
    .clk  (ACLK),
    .rst  (ARESET),
    .en   (en_s00),
    .count(S00_bhs_count)
  );

  bready_hs_counter #(
    .CNT_W(CNT_W)
  ) u_cnt_s01 (
    .clk  (ACLK),
    .rst  (ARESET),
    .en   (en_s01),
    .count(S01_bhs_count)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      sel_q       <= 1'b0;
      sel_changed <= 1'b0;
    end else begin
      sel_q       <= Selected_Slave;
      sel_changed <= (Selected_Slave != sel_q);
    end
  end

endmodule

// File: tb/tb_bready_mux_2_1.sv
// Directed bench for bready_mux_2_1: mux truth, counting,
// saturation (narrow instance), sel_changed and async reset.
module tb_bready_mux_2_1;

  logic        aclk = 1'b0;
  logic        run  = 1'b0;
  logic        areset;
  logic        sel;
  logic        s00;
  logic        s01;
  logic        bvalid;
  logic        out_w;
  logic        out_n;
  logic [15:0] c00_w;
  logic [15:0] c01_w;
  logic [1:0]  c00_n;
  logic [1:0]  c01_n;
  logic        chg_w;
  logic        chg_n;

  int vecs = 0;
  int errs = 0;

  always begin
    #5;
    if (run) aclk = ~aclk;
  end

  bready_mux_2_1 #(.CNT_W(16)) dut (
    .ACLK             (aclk),
    .ARESET           (areset),
    .Selected_Slave   (sel),
    .S00_AXI_bready   (s00),
    .S01_AXI_bready   (s01),
    .Sele_S_AXI_bvalid(bvalid),
    .Sele_S_AXI_bready(out_w),
    .S00_bhs_count    (c00_w),
    .S01_bhs_count    (c01_w),
    .sel_changed      (chg_w)
  );

  bready_mux_2_1 #(.CNT_W(2)) dut_n (
    .ACLK             (aclk),
    .ARESET           (areset),
    .Selected_Slave   (sel),
    .S00_AXI_bready   (s00),
    .S01_AXI_bready   (s01),
    .Sele_S_AXI_bvalid(bvalid),
    .Sele_S_AXI_bready(out_n),
    .S00_bhs_count    (c00_n),
    .S01_bhs_count    (c01_n),
    .sel_changed      (chg_n)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge aclk);
  endtask

  initial begin
    areset = 1'b1;
    sel    = 1'b0;
    s00    = 1'b0;
    s01    = 1'b0;
    bvalid = 1'b0;
    #1;
    chk("rst_c00", 32'(c00_w), 32'd0);
    chk("rst_c01", 32'(c01_w), 32'd0);
    chk("rst_chg", 32'(chg_w), 32'd0);

    // Combinational checks with no clock running.
    s00 = 1'b1; #1; chk("s00_hi", 32'(out_w), 32'd1);
    s00 = 1'b0; #1; chk("s00_lo", 32'(out_w), 32'd0);
    sel = 1'b1; s01 = 1'b1; #1;
    chk("s01_hi", 32'(out_w), 32'd1);
    s01 = 1'b0; #1; chk("s01_lo", 32'(out_w), 32'd0);
    sel = 1'b0; s00 = 1'b1; s01 = 1'b1; #1;
    chk("iso_0", 32'(out_w), 32'd1);
    sel = 1'b1; s00 = 1'b1; s01 = 1'b0; #1;
    chk("iso_1", 32'(out_w), 32'd0);
    sel = 1'b0; s00 = 1'b0; s01 = 1'b1; #1;
    chk("rap_0", 32'(out_w), 32'd0);
    sel = 1'b1; #1;
    chk("rap_1", 32'(out_w), 32'd1);
    sel = 1'b0; s00 = 1'b1; #1;
    chk("rap_2", 32'(out_w), 32'd1);
    chk("rap_n", 32'(out_n), 32'd1);

    run = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    sel = 1'b0; s00 = 1'b1; s01 = 1'b0; bvalid = 1'b1;
    edges(3);
    bvalid = 1'b0;
    chk("cnt_s00_3", 32'(c00_w), 32'd3);
    chk("cnt_s01_0", 32'(c01_w), 32'd0);
    chk("chg_quiet", 32'(chg_w), 32'd0);

    sel = 1'b1; s01 = 1'b1;
    edges(1);
    chk("chg_pulse", 32'(chg_w), 32'd1);
    bvalid = 1'b1;
    edges(1);
    chk("chg_clear", 32'(chg_w), 32'd0);
    edges(1);
    bvalid = 1'b0;
    chk("cnt_s01_2", 32'(c01_w), 32'd2);
    chk("cnt_s00_k", 32'(c00_w), 32'd3);

    sel = 1'b0; s00 = 1'b1; bvalid = 1'b1;
    edges(5);
    bvalid = 1'b0;
    chk("cnt_s00_8", 32'(c00_w), 32'd8);
    chk("sat_s00", 32'(c00_n), 32'd3);
    chk("sat_s01", 32'(c01_n), 32'd2);

    s00 = 1'b0; s01 = 1'b1; bvalid = 1'b1;
    edges(2);
    chk("no_hs", 32'(c00_w), 32'd8);
    chk("no_hs_u", 32'(c01_w), 32'd2);

    // Async reset between edges while handshakes stream.
    s00 = 1'b1;
    #2;
    areset = 1'b1;
    #1;
    chk("arst_c00", 32'(c00_w), 32'd0);
    chk("arst_c01", 32'(c01_w), 32'd0);
    chk("arst_out", 32'(out_w), 32'd1);
    s00 = 1'b0; #1;
    chk("arst_trk", 32'(out_w), 32'd0);
    s00 = 1'b1;
    edges(2);
    chk("arst_hold", 32'(c00_w), 32'd0);
    areset = 1'b0;
    bvalid = 1'b0;
    edges(1);
    chk("post_rst", 32'(c00_w), 32'd0);

    // Switch and handshake in the same cycle.
    sel = 1'b1; s00 = 1'b0; s01 = 1'b1; bvalid = 1'b1;
    edges(1);
    bvalid = 1'b0;
    chk("sw_s01", 32'(c01_w), 32'd1);
    chk("sw_s00", 32'(c00_w), 32'd0);
    chk("sw_chg", 32'(chg_w), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
